axi_read_slave: RTL and testbench

AXI3-style read slave that sits directly downstream of the read master's AR/R interface. It accepts one read-address transaction at a time and returns the burst as R beats from an internal word-addressed memory. It echoes RID, generates RLAST and RRESP, and computes FIXED/INCR/WRAP burst addresses. A testbench backdoor port preloads the memory.

---
 rtl/axi_read_slave.sv | 190 +++++++++++++++++++
 tb/tb_axi_read_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_slave.sv
// AXI3-style read slave: one AR at a time, FIXED/INCR/WRAP bursts served from a
// word-addressed memory with a backdoor write port. `READ_SLAVE_WAIT_EN adds a WAIT state.
module axi_read_slave #(
  parameter int BusWidth   = 32,
  parameter int tagbits    = 1,
  parameter int MemDepth   = 64,
  parameter int WaitCycles = 2
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [tagbits-1:0]          ARID,
  input  logic [BusWidth-1:0]         ARADDR,
  input  logic [3:0]                  ARLEN,
  input  logic [1:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic [1:0]                  ARLOCK,
  input  logic [3:0]                  ARCACHE,
  input  logic [2:0]                  ARPROT,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [tagbits-1:0]          RID,
  output logic [BusWidth-1:0]         RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY,
  input  logic                        mem_we,
  input  logic [$clog2(MemDepth)-1:0] mem_waddr,
  input  logic [BusWidth-1:0]         mem_wdata
);

  localparam int AW = $clog2(MemDepth);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                state, state_d;
  logic [tagbits-1:0]    rid_q;
  logic [BusWidth-1:0]   addr_q, rdata_q;
  logic [3:0]            len_q, beat_q;
  logic [1:0]            size_q, burst_q, rresp_q;
  logic                  slverr_q, rlast_q, rvalid_q;

  logic                  ar_hs, load, done, ar_slverr;
  logic [BusWidth-1:0]   bytes, wrap_mask, next_addr, ld_addr;
  logic [3:0]            ld_beat, ld_len;
  logic                  ld_slv, ld_decerr;

  logic [BusWidth-1:0]   mem [MemDepth];

  logic unused_inputs;
  assign unused_inputs = ^{ARLOCK, ARCACHE, ARPROT};

`ifdef READ_SLAVE_WAIT_EN
  localparam int WaitW = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;
  logic [WaitW-1:0] wait_q;
`else
  logic unused_wait;
  assign unused_wait = (WaitCycles != 0);
`endif

  assign ARREADY = (state == S_IDLE);
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign RVALID  = rvalid_q;

  // Illegal size/burst or a WRAP length that is not a power of two poisons the whole burst.
  assign ar_slverr = (ARSIZE == 2'b11) || (ARBURST == 2'b11) ||
                     ((ARBURST == 2'b10) && !(ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));

  always_comb begin
    bytes     = BusWidth'(1) << size_q;
    wrap_mask = ((BusWidth'(len_q) + BusWidth'(1)) << size_q) - BusWidth'(1);
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
      default: next_addr = addr_q + bytes;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    ar_hs   = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    ld_addr = next_addr;
    ld_beat = beat_q + 4'd1;
    ld_len  = len_q;
    ld_slv  = slverr_q;
    case (state)
      S_IDLE: begin
        if (ARVALID) begin
          ar_hs   = 1'b1;
          ld_addr = ARADDR;
          ld_beat = 4'd0;
          ld_len  = ARLEN;
          ld_slv  = ar_slverr;
`ifdef READ_SLAVE_WAIT_EN
          if (WaitCycles > 0) begin
            state_d = S_WAIT;
          end else begin
            load    = 1'b1;
            state_d = S_BURST;
          end
`else
          load    = 1'b1;
          state_d = S_BURST;
`endif
        end
      end
`ifdef READ_SLAVE_WAIT_EN
      S_WAIT: begin
        if (wait_q == WaitW'(WaitCycles - 1)) begin
          load    = 1'b1;
          ld_addr = addr_q;
          ld_beat = 4'd0;
          state_d = S_BURST;
        end
      end
`endif
      S_BURST: begin
        if (RREADY) begin
          if (rlast_q) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_decerr = (ld_addr >= BusWidth'(MemDepth * 4));

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      rid_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      slverr_q <= 1'b0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state <= state_d;
      if (ar_hs) begin
        rid_q    <= ARID;
        len_q    <= ARLEN;
        size_q   <= ARSIZE;
        burst_q  <= ARBURST;
        slverr_q <= ar_slverr;
      end
      if (ar_hs || load) addr_q <= ld_addr;
      if (load) begin
        beat_q   <= ld_beat;
        rvalid_q <= 1'b1;
        rlast_q  <= (ld_beat == ld_len);
        rresp_q  <= ld_slv ? 2'b10 : (ld_decerr ? 2'b11 : 2'b00);
        rdata_q  <= (ld_slv || ld_decerr) ? '0 : mem[ld_addr[AW+1:2]];
      end else if (done) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

`ifdef READ_SLAVE_WAIT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET)              wait_q <= '0;
    else if (ar_hs)          wait_q <= '0;
    else if (state == S_WAIT) wait_q <= wait_q + WaitW'(1);
  end
`endif

  // NOTE: the memory array has no reset; its contents survive ARESET and only the backdoor writes it.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Scoreboard bench for axi_read_slave: directed ARs push expected beats; a monitor
// pops and compares on every R handshake. Honours `READ_SLAVE_WAIT_EN for latency.
module tb_axi_read_slave;

`ifdef READ_SLAVE_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [0:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARSIZE, ARBURST, ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID, ARREADY;
  logic [0:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sb[$];
  beat_t mon_b;
  int    tests = 0;
  int    fails = 0;

  axi_read_slave #(.BusWidth(32), .tagbits(1), .MemDepth(64), .WaitCycles(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [0:0] id, input logic [31:0] data,
                      input logic [1:0] resp, input logic last);
    sb.push_back('{id, data, resp, last});
  endtask

  // Monitor: every accepted beat is compared with the oldest expected beat.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET && RVALID && RREADY) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %h, none expected", RDATA);
        end else begin
          mon_b = sb.pop_front();
          check("rid",   32'(RID),   32'(mon_b.id));
          check("rdata", RDATA,      mon_b.data);
          check("rresp", 32'(RRESP), 32'(mon_b.resp));
          check("rlast", 32'(RLAST), 32'(mon_b.last));
        end
      end
    end
  end

  task automatic issue_ar(input logic [0:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] size, input logic [1:0] burst);
    int n = 0;
    logic hs = 1'b0;
    @(posedge ACLK); #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARLOCK = 2'b01; ARCACHE = 4'hF; ARPROT = 3'h5; ARVALID = 1'b1;
    do begin
      @(negedge ACLK);
      hs = ARREADY;
      @(posedge ACLK); #1;
      n++;
    end while (!hs && n < 50);
    ARVALID = 1'b0;
    if (!hs) check("ar_handshake_timeout", 32'(hs), 32'd1);
  endtask

  // Follows a burst with RREADY held high: latency, back-to-back beats, ARREADY afterwards.
  task automatic wait_burst(input int nbeats);
    int n = 0;
    int cyc = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (!RVALID) check("arready_while_waiting", 32'(ARREADY), 32'd0);
    end while (!RVALID && n < 32);
    check("first_beat_latency", n, LAT);
    while (!(RVALID && RREADY && RLAST) && cyc < 64) begin
      check("arready_in_burst", 32'(ARREADY), 32'd0);
      @(negedge ACLK);
      cyc++;
    end
    check("burst_cycles", cyc + 1, nbeats);
    @(negedge ACLK);
    check("arready_after_last", 32'(ARREADY), 32'd1);
    check("rvalid_after_last",  32'(RVALID),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
    ARBURST = '0; ARLOCK = '0; ARCACHE = '0; ARPROT = '0; RREADY = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_arready", 32'(ARREADY), 32'd1);
    check("reset_rvalid",  32'(RVALID),  32'd0);
    check("reset_rlast",   32'(RLAST),   32'd0);
    check("reset_rid",     32'(RID),     32'd0);
    check("reset_rdata",   RDATA,        32'd0);
    check("reset_rresp",   32'(RRESP),   32'd0);

    @(posedge ACLK); #1;
    for (int i = 0; i < 64; i++) begin
      mem_we = 1'b1; mem_waddr = 6'(i); mem_wdata = 32'h0000_00A0 + 32'(i);
      @(posedge ACLK); #1;
    end
    mem_we = 1'b0;
    ARESET = 1'b0;
    RREADY = 1'b1;

    // INCR from 0x10: words 4..7
    push(1'b1, 32'hA4, 2'b00, 1'b0); push(1'b1, 32'hA5, 2'b00, 1'b0);
    push(1'b1, 32'hA6, 2'b00, 1'b0); push(1'b1, 32'hA7, 2'b00, 1'b1);
    issue_ar(1'b1, 32'h10, 4'd3, 2'b10, 2'b01);
    wait_burst(4);

    // WRAP from 0x18 in a 16-byte container: words 6,7,4,5
    push(1'b0, 32'hA6, 2'b00, 1'b0); push(1'b0, 32'hA7, 2'b00, 1'b0);
    push(1'b0, 32'hA4, 2'b00, 1'b0); push(1'b0, 32'hA5, 2'b00, 1'b1);
    issue_ar(1'b0, 32'h18, 4'd3, 2'b10, 2'b10);
    wait_burst(4);

    // FIXED at 0x08 with a 3-cycle stall on beat 1
    push(1'b1, 32'hA2, 2'b00, 1'b0); push(1'b1, 32'hA2, 2'b00, 1'b0);
    push(1'b1, 32'hA2, 2'b00, 1'b1);
    issue_ar(1'b1, 32'h08, 4'd2, 2'b10, 2'b00);
    repeat (LAT - 1) begin @(posedge ACLK); #1; end
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      check("stall_rvalid",  32'(RVALID),  32'd1);
      check("stall_rdata",   RDATA,        32'hA2);
      check("stall_rlast",   32'(RLAST),   32'd0);
      check("stall_rresp",   32'(RRESP),   32'd0);
      check("stall_rid",     32'(RID),     32'd1);
      check("stall_arready", 32'(ARREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    check("fixed_arready_beat1", 32'(ARREADY), 32'd0);
    @(negedge ACLK);
    check("fixed_rlast",         32'(RLAST),   32'd1);
    check("fixed_arready_last",  32'(ARREADY), 32'd0);
    @(negedge ACLK);
    check("fixed_arready_after", 32'(ARREADY), 32'd1);

    // INCR across the top of memory: word 63 then DECERR at 0x100
    push(1'b1, 32'hDF, 2'b00, 1'b0); push(1'b1, 32'h0, 2'b11, 1'b1);
    issue_ar(1'b1, 32'hFC, 4'd1, 2'b10, 2'b01);
    wait_burst(2);

    // ARSIZE=11: SLVERR on every beat
    push(1'b0, 32'h0, 2'b10, 1'b0); push(1'b0, 32'h0, 2'b10, 1'b1);
    issue_ar(1'b0, 32'h00, 4'd1, 2'b11, 2'b01);
    wait_burst(2);

    // WRAP with ARLEN=2 is illegal: SLVERR on all 3 beats
    push(1'b1, 32'h0, 2'b10, 1'b0); push(1'b1, 32'h0, 2'b10, 1'b0);
    push(1'b1, 32'h0, 2'b10, 1'b1);
    issue_ar(1'b1, 32'h10, 4'd2, 2'b10, 2'b10);
    wait_burst(3);

    // Reset while beat 2 of a 4-beat burst is presented
    push(1'b1, 32'hA8, 2'b00, 1'b0); push(1'b1, 32'hA9, 2'b00, 1'b0);
    issue_ar(1'b1, 32'h20, 4'd3, 2'b10, 2'b01);
    repeat (LAT - 1) begin @(posedge ACLK); #1; end
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("midreset_rvalid",  32'(RVALID),  32'd0);
    check("midreset_arready", 32'(ARREADY), 32'd1);
    check("midreset_rlast",   32'(RLAST),   32'd0);
    check("midreset_rdata",   RDATA,        32'd0);
    ARESET = 1'b0;
    RREADY = 1'b1;

    // Single-beat INCR after reset; memory contents retained
    push(1'b0, 32'hA0, 2'b00, 1'b1);
    issue_ar(1'b0, 32'h00, 4'd0, 2'b10, 2'b01);
    wait_burst(1);

    repeat (2) @(negedge ACLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
